// File: rtl/sum_pipe.sv
// -----------------------------------------------------------------------------
// sum_pipe
//   Pipelined add/subtract unit. The WIDTH-bit carry chain is cut into STAGES
//   equal chunks and one chunk is resolved per clock, so wide operands close
//   timing. The operand chunks that are not yet used travel with the beat, and
//   the result chunks that are already done are delayed, so all chunks of one
//   beat leave together. Flow control is valid/ready with a single global stall.
//
// Parameters
//   WIDTH   operand/result width (must be a multiple of STAGES)
//   STAGES  pipeline depth = number of carry-chain chunks (1..WIDTH)
//   SAT     1: clamp to the signed limit on overflow; 0: two's complement wrap
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake (in_ready never looks at in_valid)
//   in1, in2            operands A and B
//   cin                 carry-in, ignored when sub=1
//   sub                 0: in1+in2+cin   1: in1-in2
//   out_valid,out_ready result handshake
//   out                 result, wrapped or saturated
//   cout                carry-out of the MSB (sub: 1 = no borrow)
//   ovf                 signed overflow of the unsaturated sum
// -----------------------------------------------------------------------------
module sum_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter bit SAT    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("sum_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // One chunk of the carry chain: {carry_out, sum}.
    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             c);
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
    endfunction

    // Clamp to the signed limit in the direction of operand A's sign.
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] s,
                                                         input logic                    ovf_i,
                                                         input logic                    a_msb);
        logic signed [WIDTH-1:0] r;
        r = s;
        if (SAT && ovf_i) begin
            r = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // Per-stage state: A, B' (already inverted for subtract), partial sum,
    // carry out of the chunk finished in that stage, and beat valid.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] vld_q, vld_d;

    // Inputs seen by each stage's adder.
    logic [WIDTH-1:0]  a_st [STAGES];
    logic [WIDTH-1:0]  b_st [STAGES];
    logic [WIDTH-1:0]  s_st [STAGES];
    logic [STAGES-1:0] c_st, v_st;

    logic en;
    logic ovf_raw;

    // Global stall: everything advances unless a finished result is waiting.
    // Reset forces en so in_ready reads 1 while rst is held.
    assign en       = rst || !vld_q[LAST] || out_ready;
    assign in_ready = en;

    always_comb begin
        // Stage 0 takes the ports; subtract is A + ~B + 1.
        a_st[0] = in1;
        b_st[0] = sub ? ~in2 : in2;
        c_st[0] = sub ? 1'b1 : cin;
        s_st[0] = '0;
        v_st[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_st[k] = a_q[k-1];
            b_st[k] = b_q[k-1];
            c_st[k] = c_q[k-1];
            s_st[k] = s_q[k-1];
            v_st[k] = vld_q[k-1];
        end
    end

    always_comb begin
        logic [CHUNK:0] csum;
        csum = '0;
        for (int k = 0; k < STAGES; k++) begin
            csum     = add_chunk(a_st[k][k*CHUNK +: CHUNK], b_st[k][k*CHUNK +: CHUNK], c_st[k]);
            a_d[k]   = a_st[k];
            b_d[k]   = b_st[k];
            s_d[k]   = s_st[k];
            s_d[k][k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
            c_d[k]   = csum[CHUNK];
            vld_d[k] = v_st[k];
        end
    end

    // ---- pipeline register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    // Outputs are decoded from the last register only, so they move only on
    // an enabled edge. Masking with valid keeps them at zero after reset.
    assign ovf_raw   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                       (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    assign out_valid = vld_q[LAST];
    assign out       = vld_q[LAST] ? saturate(s_q[LAST], ovf_raw, a_q[LAST][WIDTH-1]) : '0;
    assign cout      = vld_q[LAST] & c_q[LAST];
    assign ovf       = vld_q[LAST] & ovf_raw;

endmodule
